// File: rtl/manchester_pkg.sv
// Shared types and constants for the parametrised Manchester line encoder.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF1 = 2'd1,
        HALF2 = 2'd2
    } state_t;

    localparam logic POL_THOMAS = 1'b0;
    localparam logic POL_IEEE   = 1'b1;

endpackage

// File: rtl/manchester_tx_param_half_bit_timer.sv
// Counts clocks inside one half-bit period and flags the terminal count.
module half_bit_timer
    import manchester_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 1
) (
    input  logic clock,
    input  logic reset_b,
    input  logic run,
    output logic half_tick
);

    localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] half_cnt;

    assign half_tick = run && (half_cnt == LAST_CNT);

    // Restarts from zero on every half boundary and whenever the line is idle.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            half_cnt <= '0;
        end else if (!run || half_tick) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/manchester_tx_param.sv
// NRZ word to Manchester serial encoder with valid/ready input and registered line outputs.
module manchester_tx_param
    import manchester_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int HALF_BIT_CLKS = 1,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              polarity,
    output logic              line_out,
    output logic              line_en,
    output logic              word_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic              pol_q, pol_nxt;
    logic              half_tick;
    logic              last_slot;
    logic              accept;
    logic              cur_bit_nxt;
    logic              line_out_nxt;
    logic              line_en_nxt;
    logic              word_done_nxt;

    half_bit_timer #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_half_bit_timer (
        .clock    (clock),
        .reset_b  (reset_b),
        .run      (state != IDLE),
        .half_tick(half_tick)
    );

    assign last_slot = (state == HALF2) && half_tick && (bit_cnt == LAST_BIT);
    assign tx_ready  = reset_b && ((state == IDLE) || last_slot);
    assign accept    = tx_valid && tx_ready;

    // Outputs are registered from next-state values so the line never glitches.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            pol_q     <= 1'b0;
            line_out  <= 1'b0;
            line_en   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            pol_q     <= pol_nxt;
            line_out  <= line_out_nxt;
            line_en   <= line_en_nxt;
            word_done <= word_done_nxt;
        end
    end

    // Acceptance can only happen in IDLE or the final slot of a word.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        pol_nxt     = pol_q;
        if (accept) begin
            state_nxt   = HALF1;
            shift_nxt   = tx_data;
            bit_cnt_nxt = '0;
            pol_nxt     = polarity;
        end else begin
            case (state)
                IDLE: ;
                HALF1: begin
                    if (half_tick) begin
                        state_nxt = HALF2;
                    end
                end
                HALF2: begin
                    if (last_slot) begin
                        state_nxt = IDLE;
                    end else if (half_tick) begin
                        state_nxt   = HALF1;
                        shift_nxt   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cur_bit_nxt   = MSB_FIRST ? shift_nxt[DATA_W-1] : shift_nxt[0];
        line_en_nxt   = (state_nxt != IDLE);
        word_done_nxt = last_slot;
        line_out_nxt  = 1'b0;
        if (state_nxt == HALF1) begin
            line_out_nxt = cur_bit_nxt ^ (pol_nxt == POL_IEEE);
        end else if (state_nxt == HALF2) begin
            line_out_nxt = ~(cur_bit_nxt ^ (pol_nxt == POL_IEEE));
        end
    end

endmodule

// File: tb/tb_manchester_tx_param.sv
// Scoreboard bench for manchester_tx_param: driver queues expected line patterns, monitor checks them.
module tb_manchester_tx_param;

    localparam int DATA_W   = 8;
    localparam int HBC      = 2;
    localparam bit MSB_1ST  = 1'b1;
    localparam int WORD_CYC = 2 * HBC * DATA_W;

    logic              clock = 1'b0;
    logic              reset_b;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              polarity;
    logic              line_out;
    logic              line_en;
    logic              word_done;

    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ready;
    logic       l_pol;
    logic       l_line_out;
    logic       l_line_en;
    logic       l_word_done;

    int total = 0;
    int bad   = 0;

    logic [WORD_CYC-1:0] exp_q[$];
    logic [WORD_CYC-1:0] cap;
    logic [WORD_CYC-1:0] exp_w;
    int                  cap_len = 0;
    int                  en_run  = 0;
    int                  last_run = 0;

    always #5 clock = ~clock;

    manchester_tx_param #(
        .DATA_W(DATA_W), .HALF_BIT_CLKS(HBC), .MSB_FIRST(MSB_1ST)
    ) u_dut (
        .clock(clock), .reset_b(reset_b), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .polarity(polarity), .line_out(line_out),
        .line_en(line_en), .word_done(word_done)
    );

    manchester_tx_param #(
        .DATA_W(8), .HALF_BIT_CLKS(1), .MSB_FIRST(1'b0)
    ) u_dut_lsb (
        .clock(clock), .reset_b(reset_b), .tx_data(l_data), .tx_valid(l_valid),
        .tx_ready(l_ready), .polarity(l_pol), .line_out(l_line_out),
        .line_en(l_line_en), .word_done(l_word_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Line pattern from the coding table: Thomas 1->HL 0->LH, IEEE 1->LH 0->HL.
    function automatic logic [WORD_CYC-1:0] refWord(input logic [DATA_W-1:0] d, input logic p);
        logic [WORD_CYC-1:0] r;
        logic [1:0]          pair;
        logic                b;
        r = '0;
        for (int k = 0; k < DATA_W; k++) begin
            b = MSB_1ST ? d[DATA_W-1-k] : d[k];
            if (p == 1'b0) pair = b ? 2'b10 : 2'b01;
            else           pair = b ? 2'b01 : 2'b10;
            for (int h = 0; h < HBC; h++) r = {r[WORD_CYC-2:0], pair[1]};
            for (int h = 0; h < HBC; h++) r = {r[WORD_CYC-2:0], pair[0]};
        end
        return r;
    endfunction

    // Monitor: gathers line samples per word and settles them against the queue on word_done.
    always @(negedge clock) begin
        if (!reset_b) begin
            cap     = '0;
            cap_len = 0;
            en_run  = 0;
        end else begin
            if (word_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_word_done", 64'(1), 64'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    checkOutput("word_pattern", 64'(cap), 64'(exp_w));
                    checkOutput("word_length", 64'(cap_len), 64'(WORD_CYC));
                end
                cap     = '0;
                cap_len = 0;
            end
            checkOutput("tx_ready", 64'(tx_ready), 64'((!line_en) || (cap_len == WORD_CYC - 1)));
            if (line_en) begin
                if (cap_len >= WORD_CYC) begin
                    checkOutput("word_overrun", 64'(cap_len), 64'(WORD_CYC - 1));
                end else begin
                    cap     = {cap[WORD_CYC-2:0], line_out};
                    cap_len = cap_len + 1;
                end
                en_run = en_run + 1;
            end else begin
                if (cap_len != 0) begin
                    checkOutput("line_gap", 64'(cap_len), 64'(0));
                    cap_len = 0;
                end
                checkOutput("idle_line_out", 64'(line_out), 64'(0));
                if (en_run != 0) last_run = en_run;
                en_run = 0;
            end
        end
    end

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic p, input logic [WORD_CYC-1:0] w);
        int budget;
        budget   = 4 * WORD_CYC;
        tx_data  = d;
        polarity = p;
        tx_valid = 1'b1;
        #1;
        while (!tx_ready && budget > 0) begin
            @(negedge clock);
            #1;
            budget--;
        end
        if (budget == 0) begin
            checkOutput("accept_timeout", 64'(1), 64'(0));
        end else begin
            exp_q.push_back(w);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic waitIdle();
        int budget;
        budget = 4 * WORD_CYC;
        #1;
        while ((line_en || exp_q.size() != 0) && budget > 0) begin
            @(negedge clock);
            #1;
            budget--;
        end
        if (budget == 0) checkOutput("idle_timeout", 64'(1), 64'(0));
    endtask

    // LSB-first, one clock per half: 8'h01 must read 10 then seven 01 pairs.
    task automatic runLsbTest();
        logic [15:0] lcap;
        int          en_cnt;
        int          early_done;
        logic        done_seen;
        lcap = '0; en_cnt = 0; early_done = 0; done_seen = 1'b0;
        @(negedge clock);
        l_data  = 8'h01;
        l_pol   = 1'b0;
        l_valid = 1'b1;
        #1;
        checkOutput("lsb_ready_idle", 64'(l_ready), 64'(1));
        @(posedge clock);
        @(negedge clock);
        l_valid = 1'b0;
        for (int k = 0; k < 17; k++) begin
            #1;
            if (k < 16) begin
                lcap = {lcap[14:0], l_line_out};
                if (l_line_en) en_cnt++;
                if (l_word_done) early_done++;
            end else begin
                done_seen = l_word_done;
            end
            @(negedge clock);
        end
        checkOutput("lsb_pattern", 64'(lcap), 64'(16'h9555));
        checkOutput("lsb_enable_cycles", 64'(en_cnt), 64'(16));
        checkOutput("lsb_early_done", 64'(early_done), 64'(0));
        checkOutput("lsb_word_done", 64'(done_seen), 64'(1));
    endtask

    initial begin
        int viol;
        logic [DATA_W-1:0] d;
        logic              p;
        reset_b  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        polarity = 1'b0;
        l_valid  = 1'b0;
        l_data   = '0;
        l_pol    = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_line_out", 64'(line_out), 64'(0));
        checkOutput("reset_line_en", 64'(line_en), 64'(0));
        checkOutput("reset_word_done", 64'(word_done), 64'(0));
        checkOutput("reset_tx_ready", 64'(tx_ready), 64'(0));
        @(negedge clock);
        reset_b = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(tx_ready), 64'(1));

        viol = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            #1;
            if (line_en || line_out || !tx_ready || word_done) viol++;
        end
        checkOutput("idle_window", 64'(viol), 64'(0));

        $display("[TB] directed A5 Thomas / IEEE");
        @(negedge clock);
        applyStimulus(8'hA5, 1'b0, 32'hC3C3_3C3C);
        tx_valid = 1'b0;
        waitIdle();
        applyStimulus(8'hA5, 1'b1, 32'h3C3C_C3C3);
        tx_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            polarity = ~polarity;
            @(negedge clock);
        end
        waitIdle();

        $display("[TB] back-to-back FF/00");
        applyStimulus(8'hFF, 1'b0, refWord(8'hFF, 1'b0));
        applyStimulus(8'h00, 1'b0, refWord(8'h00, 1'b0));
        tx_valid = 1'b0;
        waitIdle();
        checkOutput("b2b_contiguous", 64'(last_run), 64'(2 * WORD_CYC));

        $display("[TB] random words");
        for (int i = 0; i < 40; i++) begin
            d = DATA_W'($urandom);
            p = 1'($urandom_range(0, 1));
            applyStimulus(d, p, refWord(d, p));
            if ($urandom_range(0, 2) != 0) begin
                tx_valid = 1'b0;
                tx_data  = DATA_W'($urandom);
                repeat ($urandom_range(0, 4)) begin
                    polarity = 1'($urandom_range(0, 1));
                    @(negedge clock);
                end
            end
        end
        tx_valid = 1'b0;
        waitIdle();

        $display("[TB] reset mid-word");
        applyStimulus(8'h3C, 1'b0, refWord(8'h3C, 1'b0));
        tx_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset_b = 1'b0;
        #1;
        checkOutput("midreset_line_out", 64'(line_out), 64'(0));
        checkOutput("midreset_line_en", 64'(line_en), 64'(0));
        checkOutput("midreset_tx_ready", 64'(tx_ready), 64'(0));
        checkOutput("midreset_word_done", 64'(word_done), 64'(0));
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        #1;
        checkOutput("ready_after_midreset", 64'(tx_ready), 64'(1));
        viol = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            #1;
            if (line_en || word_done) viol++;
        end
        checkOutput("quiet_after_midreset", 64'(viol), 64'(0));

        $display("[TB] LSB-first instance");
        runLsbTest();

        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/manchester_tx_param.md
Name: manchester_tx_param

Overview:
Parametrised NRZ-to-Manchester line encoder; successor to the single-bit Mealy converter.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises them MSB- or LSB-first.
- Each bit is driven as two equal half-bit periods of HALF_BIT_CLKS clocks, with a selectable polarity convention.
- Output is registered (glitch-free) and sits between the framing logic and the line driver/pad.

Parameters:
DATA_W, 8, word width in bits (>=1)
HALF_BIT_CLKS, 1, clock cycles per half-bit (>=1)
MSB_FIRST, 1, 1 = transmit bit DATA_W-1 first; 0 = bit 0 first

Ports:
clock  input  1  rising-edge clock
reset_b  input  1  reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  encoder can accept a word this cycle
polarity  input  1  0 = Thomas (1 -> high,low; 0 -> low,high); 1 = IEEE 802.3 (1 -> low,high; 0 -> high,low)
line_out  output  1  Manchester serial output (registered)
line_en  output  1  driver enable; 1 while a word is on the line
word_done  output  1  one-cycle pulse after the last half of the last bit

Behaviour:
- Reset: reset_b, asynchronous, active-low. While low, all outputs are 0: line_out, line_en, word_done and tx_ready (tx_ready is gated with reset_b). FSM goes to IDLE; counters and shift register clear.
- Reset mid-word: line drops to 0/disabled immediately; the word is discarded; no word_done.
- All state updates on posedge clock.
- FSM states: IDLE, HALF1, HALF2.
  - IDLE: accept when tx_valid & tx_ready. Load tx_data into the shift register, latch polarity, bit_cnt=0, half_cnt=0, go to HALF1.
  - HALF1 -> HALF2 when half_cnt == HALF_BIT_CLKS-1 (half_cnt resets to 0).
  - HALF2 -> HALF1 (next bit) when half_cnt == HALF_BIT_CLKS-1 and bit_cnt != DATA_W-1. Shift the register and increment bit_cnt.
  - HALF2 on the last cycle of the last bit:
    - if tx_valid, load the next word and go to HALF1 (back-to-back, no idle gap);
    - otherwise go to IDLE.
- tx_ready is 1 in IDLE, and in HALF2 on the last cycle of the last bit; 0 otherwise.
- Output level per half: with b = current bit and p = latched polarity:
  - HALF1: line_out = b XOR p
  - HALF2: line_out = ~(b XOR p)
- Latency: line_out/line_en show the first half of the first bit in the cycle after acceptance.
  - Word duration is exactly 2*HALF_BIT_CLKS*DATA_W cycles.
  - No extra cycles between back-to-back words.
- line_en is 1 for every cycle a half-bit is driven. In IDLE: line_en=0, line_out=0.
- word_done pulses 1 in the cycle after the final half-bit completes, including on back-to-back words (it coincides with the next word's first half).
- A polarity change mid-word has no effect until the next acceptance.
- tx_data/tx_valid are ignored while tx_ready=0. The source must hold data until accepted.
- Counters are sized $clog2 of their range (minimum 1 bit).
- No wrap beyond DATA_W-1 or HALF_BIT_CLKS-1.

Decomposition:
- Package manchester_pkg holds:
  - state encoding (IDLE, HALF1, HALF2; 2-bit);
  - polarity constants POL_THOMAS=0, POL_IEEE=1.
- One sub-module, half_bit_timer: parametrised by HALF_BIT_CLKS, with a run input; it outputs a half_tick on the terminal count and clears when not running.
- The top holds the FSM, shift register, bit counter and output registers.

Test Plan:
1. DATA_W=8, HALF_BIT_CLKS=2, MSB_FIRST=1, polarity=0, send 8'hA5 -> line_out = 1100 0011 1100 0011 0011 1100 0011 1100 over 32 cycles. line_en=1 throughout; word_done pulses on cycle 33; tx_ready=1 again.
2. Same word with polarity=1 -> bitwise inverse: 0011 1100 0011 1100 1100 0011 1100 0011. Toggling polarity mid-word does not change the pattern.
3. MSB_FIRST=0, HALF_BIT_CLKS=1, polarity=0, send 8'h01 -> first bit pair 10, then seven 01 pairs; 16 cycles total.
4. Back-to-back: tx_valid held with 8'hFF then 8'h00 -> 32 contiguous line_en cycles, no gap. tx_ready high only on the transition cycle; word_done pulses at the boundary and at the end.
5. Assert reset_b low at cycle 5 of a word -> line_out=0, line_en=0, tx_ready=0 immediately. After release: IDLE, tx_ready=1, no word_done.
6. tx_valid low after reset -> line_en stays 0 and line_out 0 for 100 cycles; tx_ready=1.
